// File: rtl/elev_pkg.sv
// elev_pkg: shared types and constants for the elevator call scheduler.
package elev_pkg;

   localparam int N_FLOORS = 4;
   localparam int FLOOR_W  = 2;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_MOVE_UP   = 3'd1,
      ST_MOVE_DOWN = 3'd2,
      ST_DOOR      = 3'd3,
      ST_EMERG     = 3'd4,
      ST_FAULT     = 3'd5
   } state_t;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_t;

   // Floor number of a one-hot sensor word; meaningful only when the word is one-hot.
   function automatic logic [FLOOR_W-1:0] onehot_index(input logic [N_FLOORS-1:0] sensor);
      logic [FLOOR_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N_FLOORS; i++) begin
         if (sensor[i]) idx = FLOOR_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/elev_call_scheduler_if.sv
// elev_call_scheduler_if: call buttons, cabin sensors and cabin drive outputs.
// master = the cabin / panel side, slave = the scheduler.
interface elev_call_scheduler_if;
   import elev_pkg::*;

   logic [N_FLOORS-1:0] call_req;
   logic [N_FLOORS-1:0] floor_sensor;
   logic                emerg;
   logic                motor_up;
   logic                motor_down;
   logic                door_open;
   logic [FLOOR_W-1:0]  cur_floor;
   logic [N_FLOORS-1:0] pending;
   logic                fault;

   modport master (
      output call_req, floor_sensor, emerg,
      input  motor_up, motor_down, door_open, cur_floor, pending, fault
   );

   modport slave (
      input  call_req, floor_sensor, emerg,
      output motor_up, motor_down, door_open, cur_floor, pending, fault
   );

endinterface

// File: rtl/elev_tick_timer.sv
// elev_tick_timer: loadable down-counter that saturates at zero.
// done is high while the count is zero; a load takes priority over counting.
module elev_tick_timer #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         done
);

   logic [W-1:0] count_reg;

   // Load on request, otherwise count down and hold at zero.
   always_ff @(posedge clock) begin
      if (reset) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= value;
      end else if (count_reg != '0) begin
         count_reg <= count_reg - W'(1);
      end
   end

   assign done = (count_reg == '0);

endmodule

// File: rtl/elev_call_scheduler.sv
// elev_call_scheduler: SCAN call scheduler for a small elevator.
// Optional travel watchdog: define ELEV_TRAVEL_WATCHDOG_EN to trip FAULT when the
// cabin goes too long between floor arrivals; without it fault is tied low.
module elev_call_scheduler #(
   parameter int N_FLOORS     = 4,
   parameter int DOOR_TICKS   = 100000000,
   parameter int TRAVEL_TICKS = 250000000
) (
   input logic                  clock,
   input logic                  reset,
   elev_call_scheduler_if.slave bus
);
   import elev_pkg::*;

   localparam int TICK_MAX = (DOOR_TICKS > TRAVEL_TICKS) ? DOOR_TICKS : TRAVEL_TICKS;
   localparam int TIMER_W  = $clog2(TICK_MAX + 1);
   // The timer counts down to zero and the exit happens on the following edge,
   // so loading TICKS-1 gives exactly TICKS cycles in the state.
   localparam logic [TIMER_W-1:0] DOOR_LOAD = TIMER_W'(DOOR_TICKS - 1);
`ifdef ELEV_TRAVEL_WATCHDOG_EN
   localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_TICKS - 1);
`endif
   localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(N_FLOORS - 1);

   state_t              state_reg, state_next;
   dir_t                dir_reg, dir_next;
   logic [N_FLOORS-1:0] pending_reg, pending_next;
   logic [FLOOR_W-1:0]  cur_floor_reg, cur_floor_next;
   logic                motor_up_reg, motor_up_next;
   logic                motor_down_reg, motor_down_next;
   logic                door_open_reg, door_open_next;

   logic                sensor_valid;
   logic [FLOOR_W-1:0]  sensor_floor;
   logic [FLOOR_W-1:0]  pos;
   logic [N_FLOORS-1:0] eff;
   logic [N_FLOORS-1:0] above, below;
   logic                any_above, any_below;
   logic                head_up;
   logic [FLOOR_W-1:0]  end_floor;
   logic [N_FLOORS-1:0] serve_mask;
   logic [N_FLOORS-1:0] mask_call;
   logic                timer_load;
   logic [TIMER_W-1:0]  timer_value;
   logic                timer_done;

   // Only a clean one-hot sensor word identifies a floor.
   assign sensor_valid = $onehot(bus.floor_sensor);
   assign sensor_floor = onehot_index(bus.floor_sensor);
   assign pos          = sensor_valid ? sensor_floor : cur_floor_reg;
   // Calls pressed this cycle take part in decisions immediately.
   assign eff          = pending_reg | bus.call_req;
   assign end_floor    = (state_reg == ST_MOVE_UP) ? TOP_FLOOR : '0;

   genvar gi;
   generate
      for (gi = 0; gi < N_FLOORS; gi++) begin : g_floor
         assign above[gi] = eff[gi] && (FLOOR_W'(gi) > pos);
         assign below[gi] = eff[gi] && (FLOOR_W'(gi) < pos);
      end
   endgenerate

   assign any_above = |above;
   assign any_below = |below;

   // One timer serves both the door dwell and the travel watchdog.
   elev_tick_timer #(.W(TIMER_W)) u_timer (
      .clock (clock),
      .reset (reset),
      .load  (timer_load),
      .value (timer_value),
      .done  (timer_done)
   );

   // Next-state, call bookkeeping and registered-output decode.
   always_comb begin
      state_next  = state_reg;
      dir_next    = dir_reg;
      serve_mask  = '0;
      mask_call   = '0;
      timer_load  = 1'b0;
      timer_value = DOOR_LOAD;
      head_up     = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (sensor_valid && eff[sensor_floor]) begin
               state_next               = ST_DOOR;
               serve_mask[sensor_floor] = 1'b1;
               timer_load               = 1'b1;
               timer_value              = DOOR_LOAD;
            end else if (eff != '0) begin
               // Keep heading while work remains that way, else reverse. When parked
               // between floors with the only call at the last floor passed, the
               // reversal heads back toward it.
               if (dir_reg == DIR_UP) head_up = any_above;
               else                   head_up = !any_below;
               state_next = head_up ? ST_MOVE_UP : ST_MOVE_DOWN;
               dir_next   = head_up ? DIR_UP : DIR_DOWN;
`ifdef ELEV_TRAVEL_WATCHDOG_EN
               timer_load  = 1'b1;
               timer_value = TRAVEL_LOAD;
`endif
            end
         end

         ST_MOVE_UP, ST_MOVE_DOWN: begin
            if (sensor_valid && eff[sensor_floor]) begin
               state_next               = ST_DOOR;
               serve_mask[sensor_floor] = 1'b1;
               timer_load               = 1'b1;
               timer_value              = DOOR_LOAD;
            end else if (sensor_valid && sensor_floor == end_floor) begin
               // End of the shaft with nothing to serve here: stop, never overrun.
               state_next = ST_IDLE;
            end
`ifdef ELEV_TRAVEL_WATCHDOG_EN
            else if (sensor_valid && sensor_floor != cur_floor_reg) begin
               timer_load  = 1'b1;
               timer_value = TRAVEL_LOAD;
            end else if (timer_done) begin
               state_next = ST_FAULT;
            end
`endif
         end

         ST_DOOR: begin
            // A press for this floor keeps the door open and is not queued.
            if (bus.call_req[cur_floor_reg]) begin
               mask_call[cur_floor_reg] = 1'b1;
               timer_load               = 1'b1;
               timer_value              = DOOR_LOAD;
            end else if (timer_done) begin
               state_next = ST_IDLE;
            end
         end

         ST_EMERG: begin
            if (!bus.emerg) state_next = ST_IDLE;
         end

         ST_FAULT: begin
            state_next = ST_FAULT;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase

      // Emergency stop overrides everything except a latched fault.
      if (bus.emerg && state_reg != ST_FAULT) begin
         state_next = ST_EMERG;
         dir_next   = dir_reg;
         serve_mask = '0;
         mask_call  = '0;
         timer_load = 1'b0;
      end

      pending_next    = (pending_reg | (bus.call_req & ~mask_call)) & ~serve_mask;
      cur_floor_next  = sensor_valid ? sensor_floor : cur_floor_reg;
      motor_up_next   = (state_next == ST_MOVE_UP);
      motor_down_next = (state_next == ST_MOVE_DOWN);
      door_open_next  = (state_next == ST_DOOR) || (state_next == ST_EMERG && sensor_valid);
   end

   // State and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         dir_reg        <= DIR_UP;
         pending_reg    <= '0;
         cur_floor_reg  <= '0;
         motor_up_reg   <= 1'b0;
         motor_down_reg <= 1'b0;
         door_open_reg  <= 1'b0;
      end else begin
         state_reg      <= state_next;
         dir_reg        <= dir_next;
         pending_reg    <= pending_next;
         cur_floor_reg  <= cur_floor_next;
         motor_up_reg   <= motor_up_next;
         motor_down_reg <= motor_down_next;
         door_open_reg  <= door_open_next;
      end
   end

`ifdef ELEV_TRAVEL_WATCHDOG_EN
   logic fault_reg;

   // Fault flag mirrors the latched FAULT state.
   always_ff @(posedge clock) begin
      if (reset) fault_reg <= 1'b0;
      else       fault_reg <= (state_next == ST_FAULT);
   end

   assign bus.fault = fault_reg;
`else
   assign bus.fault = 1'b0;
`endif

   assign bus.motor_up   = motor_up_reg;
   assign bus.motor_down = motor_down_reg;
   assign bus.door_open  = door_open_reg;
   assign bus.cur_floor  = cur_floor_reg;
   assign bus.pending    = pending_reg;

endmodule

// File: tb/tb_elev_call_scheduler.sv
// tb_elev_call_scheduler: directed scenarios with hand-computed expectations.
// Observed word layout: {motor_up, motor_down, door_open, fault, cur_floor[1:0], pending[3:0]}.
module tb_elev_call_scheduler;

   logic       clock;
   logic       reset;
   int         checks = 0;
   int         errors = 0;
   logic [9:0] obs;
   logic [9:0] exp_word;

   elev_call_scheduler_if bus();

   elev_call_scheduler #(
      .N_FLOORS     (4),
      .DOOR_TICKS   (4),
      .TRAVEL_TICKS (20)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   assign obs = {bus.motor_up, bus.motor_down, bus.door_open, bus.fault, bus.cur_floor, bus.pending};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; bus.emerg = 1'b1; bus.call_req = 4'b1111; bus.floor_sensor = 4'b0100;
      step();
      exp_word = 10'b0000_00_0000; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL reset_state: got %b expected %b", obs, exp_word); end
      else $display("ok reset_state %b", obs);
      reset = 1'b0; bus.emerg = 1'b0; bus.call_req = 4'b0000; bus.floor_sensor = 4'b0001;
   endtask

   task automatic test_basic();
      bus.call_req = 4'b0100; step();
      exp_word = 10'b1000_00_0100; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL basic_depart: got %b expected %b", obs, exp_word); end
      else $display("ok basic_depart %b", obs);
      bus.call_req = 4'b0000; bus.floor_sensor = 4'b0000; step();
      exp_word = 10'b1000_00_0100; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL basic_between: got %b expected %b", obs, exp_word); end
      else $display("ok basic_between %b", obs);
      bus.floor_sensor = 4'b0010; step();
      exp_word = 10'b1000_01_0100; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL basic_pass_f1: got %b expected %b", obs, exp_word); end
      else $display("ok basic_pass_f1 %b", obs);
      bus.floor_sensor = 4'b0000; step();
      bus.floor_sensor = 4'b0100; step();
      exp_word = 10'b0010_10_0000; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL basic_arrive: got %b expected %b", obs, exp_word); end
      else $display("ok basic_arrive %b", obs);
      for (int i = 0; i < 3; i++) begin
         step();
         exp_word = 10'b0010_10_0000; checks++;
         if (obs !== exp_word) begin errors++; $display("FAIL basic_door_hold%0d: got %b expected %b", i, obs, exp_word); end
         else $display("ok basic_door_hold%0d %b", i, obs);
      end
      step();
      exp_word = 10'b0000_10_0000; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL basic_door_close: got %b expected %b", obs, exp_word); end
      else $display("ok basic_door_close %b", obs);
   endtask

   task automatic test_door_restart();
      bus.call_req = 4'b0100; step();
      exp_word = 10'b0010_10_0000; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL restart_open: got %b expected %b", obs, exp_word); end
      else $display("ok restart_open %b", obs);
      bus.call_req = 4'b0000; step();
      bus.call_req = 4'b0100; step();
      exp_word = 10'b0010_10_0000; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL restart_press: got %b expected %b", obs, exp_word); end
      else $display("ok restart_press %b", obs);
      bus.call_req = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         step();
         exp_word = 10'b0010_10_0000; checks++;
         if (obs !== exp_word) begin errors++; $display("FAIL restart_hold%0d: got %b expected %b", i, obs, exp_word); end
         else $display("ok restart_hold%0d %b", i, obs);
      end
      step();
      exp_word = 10'b0000_10_0000; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL restart_close: got %b expected %b", obs, exp_word); end
      else $display("ok restart_close %b", obs);
   endtask

   task automatic test_reverse();
      bus.call_req = 4'b0001; step();
      exp_word = 10'b0100_10_0001; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL reverse_down: got %b expected %b", obs, exp_word); end
      else $display("ok reverse_down %b", obs);
      bus.call_req = 4'b0000; bus.floor_sensor = 4'b0010; step();
      exp_word = 10'b0100_01_0001; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL reverse_pass_f1: got %b expected %b", obs, exp_word); end
      else $display("ok reverse_pass_f1 %b", obs);
      bus.floor_sensor = 4'b0001; step();
      exp_word = 10'b0010_00_0000; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL reverse_arrive_f0: got %b expected %b", obs, exp_word); end
      else $display("ok reverse_arrive_f0 %b", obs);
      repeat (4) step();
      exp_word = 10'b0000_00_0000; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL reverse_idle: got %b expected %b", obs, exp_word); end
      else $display("ok reverse_idle %b", obs);
   endtask

   task automatic test_scan();
      bus.call_req = 4'b1000; step();
      exp_word = 10'b1000_00_1000; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL scan_depart_up: got %b expected %b", obs, exp_word); end
      else $display("ok scan_depart_up %b", obs);
      bus.call_req = 4'b0001; bus.floor_sensor = 4'b0010; step();
      exp_word = 10'b1000_01_1001; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL scan_f1_calls: got %b expected %b", obs, exp_word); end
      else $display("ok scan_f1_calls %b", obs);
      bus.call_req = 4'b0000; bus.floor_sensor = 4'b0100; step();
      exp_word = 10'b1000_10_1001; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL scan_skip_f2: got %b expected %b", obs, exp_word); end
      else $display("ok scan_skip_f2 %b", obs);
      bus.floor_sensor = 4'b1000; step();
      exp_word = 10'b0010_11_0001; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL scan_serve_f3: got %b expected %b", obs, exp_word); end
      else $display("ok scan_serve_f3 %b", obs);
      repeat (4) step();
      exp_word = 10'b0000_11_0001; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL scan_idle_f3: got %b expected %b", obs, exp_word); end
      else $display("ok scan_idle_f3 %b", obs);
      step();
      exp_word = 10'b0100_11_0001; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL scan_reverse_down: got %b expected %b", obs, exp_word); end
      else $display("ok scan_reverse_down %b", obs);
      bus.floor_sensor = 4'b0100; step();
      bus.floor_sensor = 4'b0010; step();
      bus.floor_sensor = 4'b0001; step();
      exp_word = 10'b0010_00_0000; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL scan_serve_f0: got %b expected %b", obs, exp_word); end
      else $display("ok scan_serve_f0 %b", obs);
      repeat (4) step();
   endtask

   task automatic test_emerg();
      bus.call_req = 4'b1000; step();
      bus.call_req = 4'b0000; bus.floor_sensor = 4'b1000; step();
      repeat (4) step();
      bus.call_req = 4'b0001; step();
      exp_word = 10'b0100_11_0001; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL emerg_setup_down: got %b expected %b", obs, exp_word); end
      else $display("ok emerg_setup_down %b", obs);
      bus.call_req = 4'b0000; bus.floor_sensor = 4'b0000; step();
      bus.emerg = 1'b1; step();
      exp_word = 10'b0000_11_0001; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL emerg_stop: got %b expected %b", obs, exp_word); end
      else $display("ok emerg_stop %b", obs);
      bus.call_req = 4'b0010; step();
      exp_word = 10'b0000_11_0011; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL emerg_latch: got %b expected %b", obs, exp_word); end
      else $display("ok emerg_latch %b", obs);
      bus.call_req = 4'b0000; bus.floor_sensor = 4'b0100; step();
      exp_word = 10'b0010_10_0011; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL emerg_door_at_floor: got %b expected %b", obs, exp_word); end
      else $display("ok emerg_door_at_floor %b", obs);
      bus.floor_sensor = 4'b0000; bus.emerg = 1'b0; step();
      exp_word = 10'b0000_10_0011; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL emerg_exit_idle: got %b expected %b", obs, exp_word); end
      else $display("ok emerg_exit_idle %b", obs);
      step();
      exp_word = 10'b0100_10_0011; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL emerg_resume_down: got %b expected %b", obs, exp_word); end
      else $display("ok emerg_resume_down %b", obs);
   endtask

   task automatic test_reset_mid_motion();
      reset = 1'b1; step();
      exp_word = 10'b0000_00_0000; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL midreset_clear: got %b expected %b", obs, exp_word); end
      else $display("ok midreset_clear %b", obs);
      reset = 1'b0; bus.floor_sensor = 4'b0100; step();
      exp_word = 10'b0000_10_0000; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL midreset_reacquire: got %b expected %b", obs, exp_word); end
      else $display("ok midreset_reacquire %b", obs);
      step();
      exp_word = 10'b0000_10_0000; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL midreset_stay_idle: got %b expected %b", obs, exp_word); end
      else $display("ok midreset_stay_idle %b", obs);
   endtask

   task automatic test_bottom_limit();
      bus.call_req = 4'b0010; step();
      exp_word = 10'b0100_10_0010; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL limit_down: got %b expected %b", obs, exp_word); end
      else $display("ok limit_down %b", obs);
      bus.call_req = 4'b0000; bus.floor_sensor = 4'b0001; step();
      exp_word = 10'b0000_00_0010; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL limit_stop_f0: got %b expected %b", obs, exp_word); end
      else $display("ok limit_stop_f0 %b", obs);
      step();
      exp_word = 10'b1000_00_0010; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL limit_reverse_up: got %b expected %b", obs, exp_word); end
      else $display("ok limit_reverse_up %b", obs);
      bus.floor_sensor = 4'b0010; step();
      exp_word = 10'b0010_01_0000; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL limit_serve_f1: got %b expected %b", obs, exp_word); end
      else $display("ok limit_serve_f1 %b", obs);
      repeat (4) step();
   endtask

   task automatic test_watchdog();
      bus.call_req = 4'b1000; step();
      exp_word = 10'b1000_01_1000; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL wd_depart: got %b expected %b", obs, exp_word); end
      else $display("ok wd_depart %b", obs);
      bus.call_req = 4'b0000; bus.floor_sensor = 4'b0000;
`ifdef ELEV_TRAVEL_WATCHDOG_EN
      repeat (19) step();
      exp_word = 10'b1000_01_1000; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL wd_running: got %b expected %b", obs, exp_word); end
      else $display("ok wd_running %b", obs);
      step();
      exp_word = 10'b0001_01_1000; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL wd_trip: got %b expected %b", obs, exp_word); end
      else $display("ok wd_trip %b", obs);
      bus.emerg = 1'b1; step();
      exp_word = 10'b0001_01_1000; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL wd_ignore_emerg: got %b expected %b", obs, exp_word); end
      else $display("ok wd_ignore_emerg %b", obs);
      bus.emerg = 1'b0;
`else
      repeat (25) step();
      exp_word = 10'b1000_01_1000; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL nowd_still_moving: got %b expected %b", obs, exp_word); end
      else $display("ok nowd_still_moving %b", obs);
`endif
      reset = 1'b1; step();
      exp_word = 10'b0000_00_0000; checks++;
      if (obs !== exp_word) begin errors++; $display("FAIL wd_reset_clears: got %b expected %b", obs, exp_word); end
      else $display("ok wd_reset_clears %b", obs);
      reset = 1'b0;
   endtask

   initial begin
      reset            = 1'b1;
      bus.emerg        = 1'b1;
      bus.call_req     = 4'b1111;
      bus.floor_sensor = 4'b0100;
      test_reset();
      test_basic();
      test_door_restart();
      test_reverse();
      test_scan();
      test_emerg();
      test_reset_mid_motion();
      test_bottom_limit();
      test_watchdog();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/elev_call_scheduler.md
ELEV_CALL_SCHEDULER -- requirements
Module: elev_call_scheduler

Interface
REQ-001 SHALL have parameter N_FLOORS, default 4, number of served floors (fixed 4 in this revision).
REQ-002 SHALL have parameter DOOR_TICKS, default 100000000, door-open time in clock cycles (2 s at 50 MHz).
REQ-003 SHALL have parameter TRAVEL_TICKS, default 250000000, maximum cycles between floor arrivals while moving.
REQ-004 SHALL have ports: clock  in  1  system clock (50 MHz).
REQ-005 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have: call_req  in  4  active-high call buttons, bit i = floor i (inverted upstream from KEY).
REQ-007 SHALL have: floor_sensor  in  4  one-hot cabin position; all-zero = between floors.
REQ-008 SHALL have: emerg  in  1  active-high emergency stop.
REQ-009 SHALL have: motor_up, motor_down  out  1 each  motor drive.
REQ-010 SHALL have: door_open  out  1  door actuator.
REQ-011 SHALL have: cur_floor  out  2  last valid floor; pending  out  4  latched calls; fault  out  1  watchdog trip.
REQ-012 SHALL use one clock; reset is synchronous and active-high, ports named clock and reset.

Function
REQ-013 SHALL implement FSM states IDLE, MOVE_UP, MOVE_DOWN, DOOR, EMERG, FAULT; all outputs registered.
REQ-014 SHALL set pending[i] the cycle after call_req[i]=1 is sampled; bits hold until served.
REQ-015 SHALL update cur_floor only when floor_sensor is exactly one-hot; zero or multi-hot holds cur_floor.
REQ-016 IDLE: pending empty -> stay; pending[cur_floor] with valid sensor -> DOOR; else choose direction by SCAN: keep last direction if any pending in it, otherwise reverse.
REQ-017 MOVE_UP/MOVE_DOWN: one-hot sensor at floor f with pending[f] -> DOOR next cycle, motor off, pending[f] cleared, timer loaded DOOR_TICKS.
REQ-018 MOVE_UP at floor 3 or MOVE_DOWN at floor 0 with no pending at that floor -> IDLE (no wrap-around, no overrun).
REQ-019 DOOR: door_open=1 for exactly DOOR_TICKS cycles, then IDLE; call_req for cur_floor during DOOR restarts timer and does not set pending.
REQ-020 motor_up and motor_down SHALL never both be 1; door_open=1 implies both motors 0.
REQ-021 emerg=1 in any state except FAULT -> EMERG next cycle: motors 0, door_open = valid sensor present; pending retained and calls still latched.
REQ-022 EMERG exits to IDLE the cycle after emerg=0; last direction retained.
REQ-023 Last-direction register SHALL reset to up.

Reset
REQ-024 reset=1 SHALL, at the next clock edge, force IDLE, motors 0, door_open 0, cur_floor 0, pending 0, fault 0, timers 0, overriding all inputs including emerg.
REQ-025 Reset mid-motion SHALL drop all pending calls; cur_floor re-acquires from the first valid sensor.

Configuration
REQ-026 Macro ELEV_TRAVEL_WATCHDOG_EN defined: timer loads TRAVEL_TICKS on entering MOVE_* and on each new floor; expiry -> FAULT, motors 0, door 0, fault=1, exit only by reset.
REQ-027 Macro undefined: no watchdog logic, FAULT unreachable, fault tied 0.

Structure
REQ-028 Package elev_pkg SHALL hold the state enum, FLOOR_W=2, N_FLOORS constant and direction type.
REQ-029 Sub-module elev_tick_timer (loadable down-counter, load/value/done) SHALL be shared by door and watchdog timing.

Verification (DOOR_TICKS=4, TRAVEL_TICKS=20)
REQ-030 Reset, sensor=0001, call_req=0100 one cycle -> pending=0100, motor_up=1; sensor=0100 -> motor_up=0, door_open=1 for 4 cycles, pending=0000, IDLE.
REQ-031 At floor 1 moving up, calls 1000 and 0001 -> serves floor 3 first, then reverses and serves floor 0.
REQ-032 IDLE at floor 2, call_req=0100 -> no motor, door_open=1 next cycle; repeat press at cycle 2 of door -> door held 4 more cycles.
REQ-033 emerg=1 while motor_down=1, sensor=0000 -> motors 0, door_open 0 next cycle, pending kept; emerg=0 -> resumes downward.
REQ-034 ELEV_TRAVEL_WATCHDOG_EN defined, moving with sensor stuck 0000 for 20 cycles -> fault=1, motors 0; only reset clears.
